// File: rtl/bht_pkg.sv
// Shared definitions for the branch history table.
//   bht_state_e : clear-engine FSM states (IDLE, CLEAR)
//   sat_next    : one saturating up/down step of a ctr_w-bit counter
//   CTR_W_DEF / IDX_W_DEF : default counter and index widths
package bht_pkg;

  localparam int CTR_W_DEF = 2;
  localparam int IDX_W_DEF = 6;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } bht_state_e;

  // Counter is carried in a 32-bit container so one function serves any
  // width; callers truncate the result back to their counter width.
  function automatic logic [31:0] sat_next(input logic [31:0] ctr,
                                           input logic        taken,
                                           input int unsigned ctr_w);
    logic [31:0] max_v;
    max_v = (32'd1 << ctr_w) - 32'd1;
    if (taken) begin
      return (ctr != max_v) ? ctr + 32'd1 : ctr;
    end else begin
      return (ctr != 32'd0) ? ctr - 32'd1 : ctr;
    end
  endfunction

endpackage

// File: rtl/bht_ctr_next.sv
// Combinational saturating counter step.
//   ctr      : current counter value
//   taken    : branch outcome (1 = count up, 0 = count down)
//   ctr_next : next value, clamped at 0 and 2^CTR_W-1
module bht_ctr_next
  import bht_pkg::*;
#(
  parameter int CTR_W = CTR_W_DEF
) (
  input  logic [CTR_W-1:0] ctr,
  input  logic             taken,
  output logic [CTR_W-1:0] ctr_next
);

  assign ctr_next = CTR_W'(sat_next(32'(ctr), taken, CTR_W));

endmodule

// File: rtl/bht_sat_table.sv
// Branch history table: 2^IDX_W saturating counters with a registered
// lookup port, an update port with same-cycle forwarding, and a
// sequenced flush engine that rewrites every entry to INIT.
//   Clk, Rst_n        : clock, asynchronous active-low reset
//   lk_valid, lk_idx  : lookup request and index
//   pred_valid        : lookup result valid (one cycle after lk_valid)
//   pred_ctr          : counter value of the looked-up entry
//   pred_taken        : MSB of pred_ctr
//   upd_valid, upd_idx, upd_taken : resolved branch update
//   clr_req           : start a whole-table flush
//   busy              : flush in progress (updates dropped, lookups = INIT)
module bht_sat_table
  import bht_pkg::*;
#(
  parameter int CTR_W = CTR_W_DEF,
  parameter int IDX_W = IDX_W_DEF,
  parameter int INIT  = 1
) (
  input  logic             Clk,
  input  logic             Rst_n,
  input  logic             lk_valid,
  input  logic [IDX_W-1:0] lk_idx,
  output logic             pred_valid,
  output logic [CTR_W-1:0] pred_ctr,
  output logic             pred_taken,
  input  logic             upd_valid,
  input  logic [IDX_W-1:0] upd_idx,
  input  logic             upd_taken,
  input  logic             clr_req,
  output logic             busy
);

  localparam int             DEPTH  = 1 << IDX_W;
  localparam logic [CTR_W-1:0] INIT_V = CTR_W'(INIT);
  localparam logic [IDX_W-1:0] LAST   = IDX_W'(DEPTH - 1);

  logic [CTR_W-1:0] mem [DEPTH];

  bht_state_e       state;
  bht_state_e       state_nxt;
  logic [IDX_W-1:0] ptr;

  logic [CTR_W-1:0] upd_cur;
  logic [CTR_W-1:0] upd_nxt;
  logic [CTR_W-1:0] lk_cur;
  logic [CTR_W-1:0] fwd_nxt;
  logic             upd_en;
  logic             fwd_hit;

  assign upd_cur = mem[upd_idx];
  assign lk_cur  = mem[lk_idx];
  assign upd_en  = upd_valid && (state == IDLE);
  assign fwd_hit = upd_en && lk_valid && (lk_idx == upd_idx);
  assign busy    = (state == CLEAR);

  bht_ctr_next #(.CTR_W(CTR_W)) u_upd_step (
    .ctr      (upd_cur),
    .taken    (upd_taken),
    .ctr_next (upd_nxt)
  );

  // Steps the looked-up entry with the in-flight outcome; only selected
  // when the lookup and update hit the same entry.
  bht_ctr_next #(.CTR_W(CTR_W)) u_fwd_step (
    .ctr      (lk_cur),
    .taken    (upd_taken),
    .ctr_next (fwd_nxt)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (clr_req) state_nxt = CLEAR;
      CLEAR:   if (ptr == LAST) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state <= IDLE;
      ptr   <= '0;
    end else begin
      state <= state_nxt;
      if (state == CLEAR) begin
        ptr <= ptr + IDX_W'(1);
      end else if (clr_req) begin
        ptr <= '0;
      end
    end
  end

  // Single write port: flush owns it while busy, otherwise the update path.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= INIT_V;
    end else if (state == CLEAR) begin
      mem[ptr] <= INIT_V;
    end else if (upd_en) begin
      mem[upd_idx] <= upd_nxt;
    end
  end

  // Lookup result stage
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      pred_valid <= 1'b0;
      pred_ctr   <= '0;
    end else begin
      pred_valid <= lk_valid;
      if (lk_valid) begin
        if (state == CLEAR)  pred_ctr <= INIT_V;
        else if (fwd_hit)    pred_ctr <= fwd_nxt;
        else                 pred_ctr <= lk_cur;
      end
    end
  end

  assign pred_taken = pred_ctr[CTR_W-1];

endmodule

// File: tb/tb_bht_sat_table.sv
module tb_bht_sat_table;

  localparam int CTR_W = 2;
  localparam int IDX_W = 6;
  localparam int INIT  = 1;
  localparam int DEPTH = 1 << IDX_W;
  localparam int MAXC  = (1 << CTR_W) - 1;

  logic             Clk = 1'b0;
  logic             Rst_n = 1'b0;
  logic             lk_valid = 1'b0;
  logic [IDX_W-1:0] lk_idx = '0;
  logic             pred_valid;
  logic [CTR_W-1:0] pred_ctr;
  logic             pred_taken;
  logic             upd_valid = 1'b0;
  logic [IDX_W-1:0] upd_idx = '0;
  logic             upd_taken = 1'b0;
  logic             clr_req = 1'b0;
  logic             busy;

  bht_sat_table #(.CTR_W(CTR_W), .IDX_W(IDX_W), .INIT(INIT)) dut (
    .Clk        (Clk),
    .Rst_n      (Rst_n),
    .lk_valid   (lk_valid),
    .lk_idx     (lk_idx),
    .pred_valid (pred_valid),
    .pred_ctr   (pred_ctr),
    .pred_taken (pred_taken),
    .upd_valid  (upd_valid),
    .upd_idx    (upd_idx),
    .upd_taken  (upd_taken),
    .clr_req    (clr_req),
    .busy       (busy)
  );

  always #5 Clk = ~Clk;

  // Reference model: plain integer table plus "flush cycles remaining".
  int mdl [DEPTH];
  int clr_left;
  int exp_pv;
  int exp_ctr;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int sat(input int c, input bit t);
    if (t) return (c < MAXC) ? c + 1 : MAXC;
    return (c > 0) ? c - 1 : 0;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) mdl[i] = INIT;
    clr_left = 0;
    exp_pv   = 0;
    exp_ctr  = 0;
  endtask

  // One clock: drive inputs, predict, clock, compare all outputs.
  task automatic cyc(input bit lk, input int li, input bit up, input int ui,
                     input bit ut, input bit clr);
    lk_valid  = lk;
    lk_idx    = IDX_W'(li);
    upd_valid = up;
    upd_idx   = IDX_W'(ui);
    upd_taken = ut;
    clr_req   = clr;
    exp_pv = lk;
    if (lk) begin
      if (clr_left > 0)          exp_ctr = INIT;
      else if (up && ui == li)   exp_ctr = sat(mdl[ui], ut);
      else                       exp_ctr = mdl[li];
    end
    if (clr_left > 0) begin
      mdl[DEPTH - clr_left] = INIT;
      clr_left--;
    end else begin
      if (up)  mdl[ui] = sat(mdl[ui], ut);
      if (clr) clr_left = DEPTH;
    end
    @(posedge Clk);
    #1;
    chk("pred_valid", int'(pred_valid), exp_pv);
    chk("pred_ctr",   int'(pred_ctr),   exp_ctr);
    chk("pred_taken", int'(pred_taken), (exp_ctr >> (CTR_W - 1)) & 1);
    chk("busy",       int'(busy),       (clr_left > 0) ? 1 : 0);
  endtask

  task automatic idle();
    cyc(0, 0, 0, 0, 0, 0);
  endtask

  task automatic look(input int li);
    cyc(1, li, 0, 0, 0, 0);
  endtask

  task automatic upd(input int ui, input bit ut);
    cyc(0, 0, 1, ui, ut, 0);
  endtask

  int busy_cnt;
  int exp_dn [4] = '{2, 1, 0, 0};

  initial begin
    model_reset();
    #12;
    chk("rst_pred_valid", int'(pred_valid), 0);
    chk("rst_pred_ctr",   int'(pred_ctr),   0);
    chk("rst_busy",       int'(busy),       0);
    @(negedge Clk);
    Rst_n = 1'b1;
    @(posedge Clk);
    #1;

    look(5);
    chk("reset_entry", int'(pred_ctr), 1);

    for (int i = 0; i < 3; i++) upd(5, 1);
    look(5);
    chk("count_up", int'(pred_ctr), 3);
    upd(5, 1);
    look(5);
    chk("sat_top", int'(pred_ctr), 3);

    for (int i = 0; i < 4; i++) begin
      upd(5, 0);
      look(5);
      chk("count_down", int'(pred_ctr), exp_dn[i]);
    end

    cyc(1, 9, 1, 9, 1, 0);
    chk("forward", int'(pred_ctr), 2);
    cyc(1, 10, 1, 9, 1, 0);
    chk("no_forward", int'(pred_ctr), 1);

    for (int i = 0; i < 2; i++) begin
      upd(0, 1);
      upd(63, 1);
    end
    look(0);
    chk("pre_clr_0", int'(pred_ctr), 3);
    cyc(0, 0, 0, 0, 0, 1);
    busy_cnt = busy ? 1 : 0;
    for (int i = 1; i < 70; i++) begin
      if (i == 10)      cyc(1, 63, 0, 0, 0, 0);
      else if (i == 20) cyc(0, 0, 1, 7, 1, 0);
      else if (i == 30) cyc(0, 0, 0, 0, 0, 1);
      else              idle();
      if (i == 10) chk("mid_clr_look", int'(pred_ctr), 1);
      if (busy) busy_cnt++;
    end
    chk("busy_len", busy_cnt, 64);
    look(0);
    chk("clr_idx0", int'(pred_ctr), 1);
    look(63);
    chk("clr_idx63", int'(pred_ctr), 1);
    look(7);
    chk("clr_drop_upd", int'(pred_ctr), 1);

    // Async reset in the middle of a flush.
    upd(40, 1);
    upd(40, 1);
    upd(2, 0);
    cyc(0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 19; i++) idle();
    chk("busy_before_rst", int'(busy), 1);
    #2;
    Rst_n = 1'b0;
    model_reset();
    #1;
    chk("async_busy", int'(busy), 0);
    chk("async_pred_valid", int'(pred_valid), 0);
    #5;
    Rst_n = 1'b1;
    @(posedge Clk);
    #1;
    chk("post_rst_busy", int'(busy), 0);
    for (int i = 0; i < DEPTH; i++) begin
      look(i);
      chk("post_rst_entry", int'(pred_ctr), INIT);
    end

    // Randomised traffic; indices often confined to a small set to exercise
    // forwarding and saturation.
    for (int n = 0; n < 600; n++) begin
      int li;
      int ui;
      li = ($urandom_range(0, 1) == 0) ? int'($urandom_range(0, 3)) : int'($urandom_range(0, DEPTH - 1));
      ui = ($urandom_range(0, 1) == 0) ? int'($urandom_range(0, 3)) : int'($urandom_range(0, DEPTH - 1));
      cyc(bit'($urandom_range(0, 1)), li,
          bit'($urandom_range(0, 3) != 0), ui,
          bit'($urandom_range(0, 1)),
          bit'($urandom_range(0, 149) == 0));
    end
    for (int i = 0; i < DEPTH + 2; i++) idle();
    for (int i = 0; i < DEPTH; i++) look(i);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
